axis_tx_frame_fifo: RTL
=======================

// Module: axis_tx_frame_fifo
// PURPOSE
//  Store-and-forward byte FIFO placed directly upstream of the GMII transmitter (GmiiTx_AxisRx).
//  Buffers complete AXI-stream frames and releases a frame only once its last byte is stored.
//  The GMII transmitter therefore never sees an underrun mid-frame.
//  Bad frames (tuser on the last byte) and frames that do not fit are dropped here and never reach the wire.
// PARAMETERS
//  DEPTH_LOG2  11  storage depth = 2**DEPTH_LOG2 bytes (data + tlast per entry)
// PORTS
//  clock               in   1  single clock; all logic on posedge
//  reset               in   1  asynchronous, active-low reset
//  io_enq_valid        in   1  upstream byte valid
//  io_enq_ready        out  1  upstream ready
//  io_enq_bits_tdata   in   8  upstream byte
//  io_enq_bits_tlast   in   1  last byte of frame
//  io_enq_bits_tuser   in   1  frame error; sampled only with tlast
//  io_deq_valid        out  1  to GmiiTx io_axis_valid
//  io_deq_ready        in   1  from GmiiTx io_axis_ready
//  io_deq_bits_tdata   out  8  byte out
//  io_deq_bits_tlast   out  1  last byte out
//  io_deq_bits_tuser   out  1  constant 0 (bad frames never forwarded)
//  io_stat_good        out  1  1-cycle pulse: frame committed
//  io_stat_bad         out  1  1-cycle pulse: frame dropped, tuser=1
//  io_stat_ovf         out  1  1-cycle pulse: frame dropped, overflow
// BEHAVIOUR
//  Reset (reset=0, async): all pointers = 0, drop flag = 0, output stage empty.
//   All outputs are 0 except io_enq_ready; io_enq_ready = 0 while in reset.
//   Partial input frames and stored frames are discarded.
//  io_enq_ready = 1 whenever out of reset. The block never back-pressures upstream; overflow becomes a drop.
//  Pointers are DEPTH_LOG2+1 bits, with the MSB used as wrap bit.
//   wr_ptr: speculative write position. wr_cmt: committed end. rd_ptr: read position.
//   All pointers wrap modulo 2**(DEPTH_LOG2+1).
//  Full: (wr_ptr - rd_ptr) == 2**DEPTH_LOG2, evaluated on registered values.
//   A write in a full cycle is an overflow even if a read frees an entry in the same cycle.
//  Write FSM states:
//   ST_FRAME: on enq handshake, if !full, store {tdata,tlast} and increment wr_ptr; otherwise go to ST_DROP.
//   ST_DROP: accept and discard bytes until tlast.
//  On the tlast handshake edge:
//   - tuser=1 (either state): wr_ptr <= wr_cmt; io_stat_bad pulses.
//   - ST_DROP, or full on that beat: wr_ptr <= wr_cmt; io_stat_ovf pulses. tuser=1 takes priority; only one pulse.
//   - otherwise: byte stored; wr_cmt <= wr_ptr+1; io_stat_good pulses.
//   Next state is always ST_FRAME.
//  Frames longer than 2**DEPTH_LOG2 are always dropped.
//  A 1-byte frame (tlast on the first beat) is legal.
//  Read side: data is available when rd_ptr != wr_cmt. Uncommitted bytes are never read.
//   Memory read is registered, followed by a 2-entry output stage (skid).
//   The output stage sustains 1 byte/cycle while io_deq_ready=1.
//  Latency: io_deq_valid rises exactly 2 clock edges after the committing tlast edge when the FIFO was empty.
//  Once io_deq_valid=1, io_deq_bits_* hold stable until the io_deq_ready handshake.
//  A frame is always streamed in order. Consecutive frames are back-to-back with no idle cycle; inter-frame gap is the transmitter's job.
//  Simultaneous commit and read: both take effect. The read side uses the old wr_cmt that cycle.
// TESTING
//  1. Send a 32-byte frame 0x00..0x1F with tuser=0 and io_deq_ready=1.
//     Expect: io_stat_good pulses once; io_deq_valid 2 edges after tlast.
//     Expect: bytes 0x00..0x1F on 32 consecutive cycles, tlast only on 0x1F.
//  2. Send a 20-byte frame with tuser=1 on tlast, then a 5-byte frame 0xA0..0xA4.
//     Expect: io_stat_bad pulses; only 0xA0..0xA4 appear at the output.
//  3. DEPTH_LOG2=6, io_deq_ready=0: send 40-byte frame A, then 40-byte frame B.
//     Expect: A good; B io_stat_ovf (full at byte 24 of B).
//     Then set io_deq_ready=1. Expect: exactly A's 40 bytes, no B bytes.
//  4. DEPTH_LOG2=6: send a 100-byte frame, then a 3-byte frame.
//     Expect: one io_stat_ovf pulse, io_enq_ready held 1, only the 3-byte frame is output.
//  5. 64-byte frame with io_deq_ready toggling 1,0,1,0.
//     Expect: every byte held stable while stalled; all 64 delivered in order.
//  6. Drive reset=0 asynchronously mid-output of a frame.
//     Expect: io_deq_valid=0 immediately.
//     After release: io_deq_valid stays 0 until a new frame commits.

Source files
------------

// File: rtl/axis_tx_frame_fifo_if.sv
// Purpose: the byte-stream and statistics bundle for axis_tx_frame_fifo.
// Ports  : enq side (valid/ready/tdata/tlast/tuser), deq side (valid/ready/tdata/tlast/tuser),
//          and the good/bad/ovf statistic pulses. The slave modport is the FIFO's view; master is the peer's.
interface axis_tx_frame_fifo_if;
  logic       io_enq_valid;
  logic       io_enq_ready;
  logic [7:0] io_enq_bits_tdata;
  logic       io_enq_bits_tlast;
  logic       io_enq_bits_tuser;
  logic       io_deq_valid;
  logic       io_deq_ready;
  logic [7:0] io_deq_bits_tdata;
  logic       io_deq_bits_tlast;
  logic       io_deq_bits_tuser;
  logic       io_stat_good;
  logic       io_stat_bad;
  logic       io_stat_ovf;

  modport slave (
    input  io_enq_valid, io_enq_bits_tdata, io_enq_bits_tlast, io_enq_bits_tuser, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_bits_tdata, io_deq_bits_tlast, io_deq_bits_tuser,
    output io_stat_good, io_stat_bad, io_stat_ovf
  );

  modport master (
    output io_enq_valid, io_enq_bits_tdata, io_enq_bits_tlast, io_enq_bits_tuser, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_bits_tdata, io_deq_bits_tlast, io_deq_bits_tuser,
    input  io_stat_good, io_stat_bad, io_stat_ovf
  );
endinterface

// File: rtl/axis_tx_frame_fifo.sv
// Purpose: store-and-forward frame FIFO ahead of the GMII transmitter; drops bad and oversize frames.
// Latency: io_deq_valid rises 2 edges after the committing tlast edge into an empty FIFO.
// Backpressure: never stalls upstream (overflow becomes a drop); io_deq_ready stalls a 2-entry skid stage.
// Ports  : clock, reset (async active-low), bus (slave modport: enq stream in, deq stream out, stat pulses).
module axis_tx_frame_fifo #(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  axis_tx_frame_fifo_if.slave   bus
);

  localparam int                C_PW    = DEPTH_LOG2 + 1;
  localparam int                C_N     = 1 << DEPTH_LOG2;
  localparam logic [C_PW-1:0]   C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {ST_FRAME, ST_DROP} wr_state_t;

  // write side
  wr_state_t        r_state, w_state_nxt;
  logic [C_PW-1:0]  r_wr_ptr, w_wr_ptr_nxt;
  logic [C_PW-1:0]  r_wr_cmt, w_wr_cmt_nxt;
  logic [C_PW-1:0]  r_rd_ptr;
  logic             w_full;
  logic             w_enq_fire;
  logic             w_wr_en;
  logic             w_good, w_bad, w_ovf;
  logic             r_stat_good, r_stat_bad, r_stat_ovf;

  // storage: {tlast, tdata}
  logic [8:0]       r_mem [C_N];

  // read side
  logic             w_rd_avail;
  logic             w_issue;
  logic             w_pop;
  logic [1:0]       w_occ;
  logic             r_mem_vld;
  logic [8:0]       r_mem_dat;
  logic [8:0]       r_ob0, r_ob1;
  logic [1:0]       r_ob_cnt;

  // Ready tracks reset directly so it is low for exactly as long as reset is held.
  assign bus.io_enq_ready = reset;
  assign w_enq_fire       = bus.io_enq_valid && reset;

  // Full is judged on registered pointers: a read in the same cycle does not rescue a write.
  assign w_full = (r_wr_ptr - r_rd_ptr) == C_DEPTH;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_FRAME;
      r_wr_ptr    <= '0;
      r_wr_cmt    <= '0;
      r_stat_good <= 1'b0;
      r_stat_bad  <= 1'b0;
      r_stat_ovf  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_wr_cmt    <= w_wr_cmt_nxt;
      r_stat_good <= w_good;
      r_stat_bad  <= w_bad;
      r_stat_ovf  <= w_ovf;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_wr_cmt_nxt = r_wr_cmt;
    w_wr_en      = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    w_ovf        = 1'b0;
    if (w_enq_fire) begin
      w_wr_en = (r_state == ST_FRAME) && !w_full;
      if (bus.io_enq_bits_tlast) begin
        w_state_nxt = ST_FRAME;
        if (bus.io_enq_bits_tuser) begin
          // error wins over overflow; rewinding discards anything written speculatively
          w_wr_ptr_nxt = r_wr_cmt;
          w_bad        = 1'b1;
        end else if (!w_wr_en) begin
          w_wr_ptr_nxt = r_wr_cmt;
          w_ovf        = 1'b1;
        end else begin
          w_wr_ptr_nxt = r_wr_ptr + C_PW'(1);
          w_wr_cmt_nxt = r_wr_ptr + C_PW'(1);
          w_good       = 1'b1;
        end
      end else if (w_wr_en) begin
        w_wr_ptr_nxt = r_wr_ptr + C_PW'(1);
      end else begin
        w_state_nxt = ST_DROP;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {bus.io_enq_bits_tlast, bus.io_enq_bits_tdata};
    end
  end

  // Read side. Only committed bytes are visible (rd_ptr chases wr_cmt).
  // A read is issued only if the skid stage is guaranteed a free slot when the
  // read data lands next cycle, assuming no pop then: occupancy after this edge <= 1.
  assign w_rd_avail = r_rd_ptr != r_wr_cmt;
  assign w_pop      = (r_ob_cnt != 2'd0) && bus.io_deq_ready;
  assign w_occ      = r_ob_cnt + {1'b0, r_mem_vld} - {1'b0, w_pop};
  assign w_issue    = w_rd_avail && (w_occ <= 2'd1);

  always_ff @(posedge clock) begin
    if (w_issue) begin
      r_mem_dat <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr  <= '0;
      r_mem_vld <= 1'b0;
      r_ob0     <= '0;
      r_ob1     <= '0;
      r_ob_cnt  <= 2'd0;
    end else begin
      r_mem_vld <= w_issue;
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + C_PW'(1);
      end
      // 2-entry skid: r_ob0 is the head presented downstream.
      if (w_pop) begin
        if (r_ob_cnt == 2'd2) begin
          r_ob0 <= r_ob1;
          if (r_mem_vld) begin
            r_ob1 <= r_mem_dat;
          end
        end else if (r_mem_vld) begin
          r_ob0 <= r_mem_dat;
        end
      end else if (r_mem_vld) begin
        if (r_ob_cnt == 2'd0) begin
          r_ob0 <= r_mem_dat;
        end else begin
          r_ob1 <= r_mem_dat;
        end
      end
      r_ob_cnt <= r_ob_cnt + {1'b0, r_mem_vld} - {1'b0, w_pop};
    end
  end

  assign bus.io_deq_valid      = r_ob_cnt != 2'd0;
  assign bus.io_deq_bits_tdata = r_ob0[7:0];
  assign bus.io_deq_bits_tlast = r_ob0[8];
  assign bus.io_deq_bits_tuser = 1'b0;
  assign bus.io_stat_good      = r_stat_good;
  assign bus.io_stat_bad       = r_stat_bad;
  assign bus.io_stat_ovf       = r_stat_ovf;

endmodule
